// File: rtl/alu_op_issuer_if.sv
// Request / ALU-drive / response signal bundle for alu_op_issuer.
// The master side is the issuer; the slave side is the requester, ALU and consumer.
interface alu_op_issuer_if;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_funct;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] alu_dataA;
  logic [31:0] alu_dataB;
  logic [5:0]  alu_Signal;
  logic        alu_reset;
  logic [31:0] alu_dataOut;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_overflow;
  logic        out_illegal;
  logic        busy;

  modport master (
    input  in_valid, in_funct, in_a, in_b, alu_dataOut, out_ready,
    output in_ready, alu_dataA, alu_dataB, alu_Signal, alu_reset,
           out_valid, out_result, out_zero, out_overflow, out_illegal, busy
  );

  modport slave (
    output in_valid, in_funct, in_a, in_b, alu_dataOut, out_ready,
    input  in_ready, alu_dataA, alu_dataB, alu_Signal, alu_reset,
           out_valid, out_result, out_zero, out_overflow, out_illegal, busy
  );
endinterface

// File: rtl/alu_op_issuer.sv
// Issues one R-type operation to a combinational 32-bit ALU, waits a settle window,
// then returns the captured result with zero/overflow/illegal flags over valid/ready.
module alu_op_issuer #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 4
) (
  input  logic              clk,
  input  logic              reset,
  alu_op_issuer_if.master   bus
);

  localparam logic [5:0] F_ADD = 6'd32;
  localparam logic [5:0] F_SUB = 6'd34;
  localparam logic [5:0] F_AND = 6'd36;
  localparam logic [5:0] F_OR  = 6'd37;
  localparam logic [5:0] F_SLT = 6'd42;

  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic             legal;
  logic             ovf_next;

  assign bus.in_ready = (state == IDLE);
  assign bus.busy     = (state != IDLE);

  always_comb begin
    legal = (bus.in_funct == F_ADD) || (bus.in_funct == F_SUB) ||
            (bus.in_funct == F_AND) || (bus.in_funct == F_OR)  ||
            (bus.in_funct == F_SLT);
  end

  // Operands are taken from the ALU drive registers, which hold the latched request.
  always_comb begin
    ovf_next = 1'b0;
    case (bus.alu_Signal)
      F_ADD: ovf_next = (bus.alu_dataA[31] == bus.alu_dataB[31]) &&
                        (bus.alu_dataOut[31] != bus.alu_dataA[31]);
      F_SUB: ovf_next = (bus.alu_dataA[31] != bus.alu_dataB[31]) &&
                        (bus.alu_dataOut[31] != bus.alu_dataA[31]);
      default: ovf_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid) state_next = legal ? SETTLE : DONE;
      SETTLE:  if (cnt == '0) state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt              <= '0;
      bus.alu_dataA    <= '0;
      bus.alu_dataB    <= '0;
      bus.alu_Signal   <= '0;
      bus.alu_reset    <= 1'b1;
      bus.out_valid    <= 1'b0;
      bus.out_result   <= '0;
      bus.out_zero     <= 1'b0;
      bus.out_overflow <= 1'b0;
      bus.out_illegal  <= 1'b0;
    end else begin
      // The ALU is released from reset only while an operation is settling.
      bus.alu_reset <= (state_next != SETTLE);
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            if (legal) begin
              bus.alu_dataA  <= bus.in_a;
              bus.alu_dataB  <= bus.in_b;
              bus.alu_Signal <= bus.in_funct;
              cnt            <= CNT_W'(SETTLE_CYCLES - 1);
            end else begin
              bus.out_result   <= '0;
              bus.out_zero     <= 1'b1;
              bus.out_overflow <= 1'b0;
              bus.out_illegal  <= 1'b1;
              bus.out_valid    <= 1'b1;
            end
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            bus.out_result   <= bus.alu_dataOut;
            bus.out_zero     <= (bus.alu_dataOut == '0);
            bus.out_overflow <= ovf_next;
            bus.out_illegal  <= 1'b0;
            bus.out_valid    <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) bus.out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/alu_op_issuer.md
Name: alu_op_issuer

Overview:
- Initiator side of the 32-bit ripple-carry ALU interface.
- Accepts one operation per handshake: a 6-bit R-type funct code plus two operands.
- Validates the funct code and drives the ALU's dataA/dataB/Signal/reset inputs.
- Holds them stable for a programmable settle window, then captures dataOut, derives zero/overflow flags, and returns the result through a valid/ready handshake.

Parameters:
- SETTLE_CYCLES, 2, cycles the ALU inputs are held before dataOut is sampled; legal range 1..15.
- CNT_W, 4, width of the settle counter; must satisfy 2^CNT_W > SETTLE_CYCLES.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- in_funct  input  6  operation code: AND=36, OR=37, ADD=32, SUB=34, SLT=42.
- in_a  input  32  operand A.
- in_b  input  32  operand B.
- alu_dataA  output  32  operand A to the ALU.
- alu_dataB  output  32  operand B to the ALU.
- alu_Signal  output  6  funct code to the ALU.
- alu_reset  output  1  active-high ALU output clear.
- alu_dataOut  input  32  combinational ALU result.
- out_valid  output  1  response valid.
- out_ready  input  1  consumer accepts the response.
- out_result  output  32  captured result.
- out_zero  output  1  out_result == 0.
- out_overflow  output  1  signed overflow for ADD/SUB.
- out_illegal  output  1  funct code was not one of the five legal codes.
- busy  output  1  state != IDLE.

Behaviour:
- Clock and reset: single clock; reset is synchronous and active-low. Sampled low at any rising edge:
  - state=IDLE, counter=0.
  - alu_dataA/alu_dataB/alu_Signal=0, alu_reset=1.
  - out_valid=0, out_result=0, all flags=0.
  - Reset overrides everything, including mid-SETTLE and mid-DONE; the in-flight operation is dropped with no response.
- States: IDLE, SETTLE, DONE. All outputs are registered except in_ready (= state==IDLE) and busy.
- IDLE:
  - in_ready=1, alu_reset=1.
  - Accept on in_valid && in_ready at an edge; latch in_a, in_b and in_funct.
  - Legal funct: load alu_dataA/alu_dataB/alu_Signal, counter=SETTLE_CYCLES-1, go to SETTLE.
  - Illegal funct: alu_* unchanged, out_result=0, out_illegal=1, out_zero=1, out_overflow=0, out_valid=1, go to DONE. The ALU is never released from reset for an illegal code.
- SETTLE:
  - alu_reset=0; alu_dataA/alu_dataB/alu_Signal held constant.
  - Counter decrements each edge.
  - At the edge where counter==0: capture out_result=alu_dataOut and compute flags, set out_valid=1, alu_reset=1, go to DONE.
  - Latency: out_valid rises exactly SETTLE_CYCLES edges after the accept edge.
- Flags, computed from the latched operands and the captured result r:
  - ADD: overflow = (a[31]==b[31]) && (r[31]!=a[31]).
  - SUB: overflow = (a[31]!=b[31]) && (r[31]!=a[31]).
  - AND/OR/SLT: overflow=0.
  - out_zero = (r==0).
  - SLT results are passed through unmodified: the ALU returns 0/1 from the difference sign bit.
- DONE:
  - out_valid=1; out_result and all flags held stable while out_ready=0.
  - On an edge with out_ready=1: out_valid=0, go to IDLE.
  - No same-edge re-accept: in_ready returns one cycle after the response handshake.
  - in_valid is ignored while busy.
  - Back-to-back throughput is one operation per SETTLE_CYCLES+2 cycles when out_ready is held high.
- alu_dataA/alu_dataB/alu_Signal keep their last issued values in IDLE and DONE; alu_reset forces the ALU output to 0 there.
- alu_Signal only ever carries one of the five legal codes, or 0 after reset.

Test Plan:
- ADD: SETTLE_CYCLES=2, funct=32, a=5, b=7, out_ready=1 -> out_valid 2 edges after accept, out_result=12, zero=0, overflow=0, in_ready high again 1 cycle after the response.
- SUB overflow: funct=34, a=0x80000000, b=1 -> out_result=0x7FFFFFFF, overflow=1. ADD a=0x7FFFFFFF, b=1 -> 0x80000000, overflow=1.
- SLT and AND: SLT a=3, b=5 -> out_result=1. AND a=0xF0F0F0F0, b=0x0F0F0F0F -> out_result=0, zero=1. alu_reset=0 only during SETTLE.
- Illegal funct=0 and funct=33 -> out_valid 1 edge after accept, out_illegal=1, out_result=0, alu_reset remains 1 throughout.
- Backpressure: out_ready=0 for 5 cycles with in_valid pulsing -> out_result and flags stable, in_ready=0, no new accept. Single-cycle out_ready -> IDLE, then the next request is accepted.
- Reset during SETTLE (reset=0 for one edge) -> all outputs 0, alu_reset=1, no response. A following ADD 1+1 returns 2 normally.
